// File: rtl/whack_score_keeper.sv
// Score, round timer and session high score for the mole game (IDLE/PLAYING/OVER).
// Optional macro WHACK_MISS_PENALTY_EN: a miss in PLAYING takes one point off the score.
module whack_score_keeper #(
    parameter int TICK_CYCLES  = 50000000,
    parameter int GAME_SECONDS = 30,
    parameter int MAX_SCORE    = 99
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [7:0] score,
    output logic       score_strobe,
    output logic [7:0] time_left,
    output logic [7:0] high_score,
    output logic       playing,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    localparam int          PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [7:0]  ROUND_SECS = 8'(GAME_SECONDS);
    localparam logic [7:0]  SCORE_MAX  = 8'(MAX_SCORE);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      score_q, score_d;
    logic [7:0]      time_q, time_d;
    logic [7:0]      high_q, high_d;
    logic            strobe_q;
    logic [7:0]      score_adj;
    logic            tick;

    // Score after this cycle's hit/miss, saturating at both ends.
`ifdef WHACK_MISS_PENALTY_EN
    always_comb begin
        score_adj = score_q;
        if (hit && !miss && (score_q < SCORE_MAX))
            score_adj = score_q + 8'd1;
        else if (miss && !hit && (score_q != 8'd0))
            score_adj = score_q - 8'd1;
    end
`else
    logic unused_miss;
    assign unused_miss = miss;

    always_comb begin
        score_adj = score_q;
        if (hit && (score_q < SCORE_MAX))
            score_adj = score_q + 8'd1;
    end
`endif

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        score_d = score_q;
        time_d  = time_q;
        high_d  = high_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_PLAYING;
                    presc_d = '0;
                    score_d = 8'd0;
                    time_d  = ROUND_SECS;
                end
            end
            S_PLAYING: begin
                score_d = score_adj;
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    time_d = time_q - 8'd1;
                    // The final-tick hit is already folded into score_adj.
                    if (time_q == 8'd1) begin
                        state_d = S_OVER;
                        if (score_adj > high_q)
                            high_d = score_adj;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // score_strobe is a valid-only qualifier on score: high for exactly the one
    // cycle a new value appears, never held, and there is no ready/backpressure.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            score_q  <= 8'd0;
            time_q   <= ROUND_SECS;
            high_q   <= 8'd0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            score_q  <= score_d;
            time_q   <= time_d;
            high_q   <= high_d;
            strobe_q <= (score_d != score_q);
        end
    end

    assign score        = score_q;
    assign score_strobe = strobe_q;
    assign time_left    = time_q;
    assign high_score   = high_q;
    assign playing      = (state_q == S_PLAYING);
    assign game_over    = (state_q == S_OVER);

endmodule

// File: tb/tb_whack_score_keeper.sv
// Bench for whack_score_keeper: directed rounds then random pulses, checked every
// cycle against a round-elapsed-time reference model through an expected queue.
module tb_whack_score_keeper;

    localparam int TC = 4;
    localparam int GS = 3;
    localparam int MS = 9;
`ifdef WHACK_MISS_PENALTY_EN
    localparam bit PENALTY = 1'b1;
`else
    localparam bit PENALTY = 1'b0;
`endif

    logic       Clock;
    logic       Reset;
    logic       start, hit, miss;
    logic [7:0] score, time_left, high_score;
    logic       score_strobe, playing, game_over;

    whack_score_keeper #(
        .TICK_CYCLES (TC),
        .GAME_SECONDS(GS),
        .MAX_SCORE   (MS)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .start       (start),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .score_strobe(score_strobe),
        .time_left   (time_left),
        .high_score  (high_score),
        .playing     (playing),
        .game_over   (game_over)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        hit   = 1'b0;
        miss  = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // {score, strobe, time_left, high_score, playing, game_over}
    logic [26:0] exp_q[$];
    int m_phase   = 0;   // 0 idle, 1 playing, 2 over
    int m_elapsed = 0;   // cycles sampled in PLAYING since start
    int m_score   = 0;
    int m_high    = 0;
    int tests     = 0;
    int fails     = 0;

    task automatic drive(input logic r, input logic s, input logic h, input logic m);
        int prev;
        int delta;
        @(negedge Clock);
        Reset = r;
        start = s;
        hit   = h;
        miss  = m;
        prev  = m_score;
        if (r) begin
            m_phase = 0; m_score = 0; m_elapsed = 0; m_high = 0;
        end else if (m_phase != 1) begin
            if (s) begin
                m_phase = 1; m_score = 0; m_elapsed = 0;
            end
        end else begin
            m_elapsed++;
            delta = int'(h);
            if (PENALTY) delta = delta - int'(m);
            m_score = m_score + delta;
            if (m_score > MS) m_score = MS;
            if (m_score < 0)  m_score = 0;
            if (m_elapsed == GS * TC) begin
                m_phase = 2;
                if (m_score > m_high) m_high = m_score;
            end
        end
        exp_q.push_back({8'(m_score), (!r && (m_score != prev)), 8'(GS - m_elapsed / TC),
                         8'(m_high), (m_phase == 1), (m_phase == 2)});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [26:0] exp;
        logic [26:0] got;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {score, score_strobe, time_left, high_score, playing, game_over};
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL outputs t=%0t got score=%0d strobe=%0b time=%0d high=%0d play=%0b over=%0b required score=%0d strobe=%0b time=%0d high=%0d play=%0b over=%0b",
                             $time, got[26:19], got[18], got[17:10], got[9:2], got[1], got[0],
                             exp[26:19], exp[18], exp[17:10], exp[9:2], exp[1], exp[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);             // Reset beats start
        drive(1'b0, 1'b0, 1'b1, 1'b1);             // IDLE ignores hit/miss
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        // Round 1: empty round, timer 3,2,1,0
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(GS * TC);
        drive(1'b0, 1'b0, 1'b1, 1'b1);             // OVER ignores hit/miss
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        // Round 2: five separated hits -> high 5
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < GS * TC; i++)
            drive(1'b0, 1'b0, ((i % 2) == 0) && (i < 10), 1'b0);
        // Round 3: seven hits plus one on the final tick -> 8
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < GS * TC; i++)
            drive(1'b0, 1'b0, (i < 7) || (i == GS * TC - 1), 1'b0);
        // Round 4: ends at 6, high stays 8; start mid-round ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < GS * TC; i++)
            drive(1'b0, i == 3, i < 6, 1'b0);
        // Round 5: hit every cycle, saturates at MS
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (GS * TC) drive(1'b0, 1'b0, 1'b1, 1'b0);
        // Round 6: miss handling
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(GS * TC - 5);
        // Round 7: Reset mid-round at score 4, time_left 2
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        // Random pulses
        repeat (3000)
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge Clock);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/whack_score_keeper.md
Name: whack_score_keeper

Overview:
Game-side score producer for the mole game. Accumulates hit events into a saturating binary score, runs the round countdown timer, and tracks the session high score. Its `score` output drives the score display's 8-bit data input; `time_left` and `high_score` can feed further display pairs. Sits between the mole/key match logic (which produces `hit`/`miss` pulses) and the hex display block.

Parameters:
- TICK_CYCLES, 50000000: clock cycles per game second (50 MHz board clock); benches use small values.
- GAME_SECONDS, 30: round length in seconds; range 1..99.
- MAX_SCORE, 99: score saturation value; must be ≤ 99 so two decimal digits suffice.

Ports:
- Clock, input, 1: system clock; all logic on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse; begins a round from IDLE or OVER.
- hit, input, 1: single-cycle pulse per successful whack.
- miss, input, 1: single-cycle pulse per wrong or empty whack.
- score, output, 8: current round score, binary, 0..MAX_SCORE.
- score_strobe, output, 1: high for one cycle in the same cycle `score` shows a new value.
- time_left, output, 8: remaining seconds, binary.
- high_score, output, 8: best final score since Reset.
- playing, output, 1: high in PLAYING.
- game_over, output, 1: high in OVER.

Behaviour:
- All outputs are registered. Every event sampled at edge N is visible after edge N, i.e. 1-cycle latency.
- Reset (dominates everything, including mid-round):
  - state IDLE; score = 0; score_strobe = 0; time_left = GAME_SECONDS; high_score = 0; playing = 0; game_over = 0; prescaler = 0.
- FSM states are IDLE, PLAYING and OVER.
- IDLE:
  - hit and miss are ignored.
  - start → PLAYING with score = 0, time_left = GAME_SECONDS, prescaler = 0.
  - score_strobe pulses only if score was nonzero.
- PLAYING:
  - The prescaler counts 0..TICK_CYCLES-1 and wraps to 0. On the wrap cycle, time_left decrements by 1.
  - When the wrap occurs with time_left == 1: time_left becomes 0 and the state goes to OVER. A round therefore lasts exactly GAME_SECONDS × TICK_CYCLES cycles after start is sampled.
  - start is ignored while PLAYING.
- Score arithmetic:
  - hit gives score = min(score + 1, MAX_SCORE).
  - score_strobe is asserted only when the value actually changes, so there is no strobe at saturation.
  - A hit in the same cycle as the final tick is counted, and that count is included in the high-score compare.
- Transition PLAYING → OVER: high_score becomes max(high_score, final score), using an unsigned compare. An equal score leaves it unchanged.
- OVER:
  - score and time_left hold; hit and miss are ignored.
  - start → PLAYING, with the same initialisation as from IDLE.
  - high_score persists across rounds and is cleared only by Reset.
- playing and game_over are decoded from the registered state and are never both high.
- Simultaneous start and Reset: Reset wins.

Optional Feature:
- Macro: WHACK_MISS_PENALTY_EN.
- Defined:
  - miss in PLAYING gives score = max(score - 1, 0), with score_strobe only on change (no underflow below 0).
  - hit and miss in the same cycle leave score unchanged, with no strobe.
- Undefined:
  - miss is ignored entirely, and hit alone decides the score.
  - The port is still present.

Test Plan:
- Params TICK_CYCLES=4, GAME_SECONDS=3. Reset, then pulse start → playing = 1 next cycle, time_left = 3. time_left reads 2, 1, 0 at +4, +8, +12 cycles. game_over = 1 and playing = 0 at +12. score = 0 and high_score = 0.
- During a round, 5 hit pulses on separate cycles → score reads 1..5, each with a 1-cycle score_strobe. At round end, high_score = 5. A new start clears score to 0 (strobe) while high_score stays 5.
- MAX_SCORE=3, 5 hits → score saturates at 3. Exactly 3 strobes.
- Hit on the exact cycle of the final tick with score = 7 → score = 8, game_over = 1, high_score = 8. A following round ending at 6 keeps high_score = 8.
- With WHACK_MISS_PENALTY_EN:
  - score = 0, miss → score stays 0 with no strobe.
  - score = 2, miss → 1.
  - hit+miss in the same cycle → unchanged.
  - Without the macro, a miss never alters score.
- Assert Reset mid-round with score = 4, time_left = 2 → next cycle IDLE, score = 0, time_left = 3, high_score = 0. Hit and miss in IDLE and OVER → no change.
